// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
// Small register file with one pending ("scoreboard") bit per register and a
// sequential clear engine that zeroes one register per cycle.
//
// Parameters:
//   WIDTH    - data width of each register
//   ADDR_W   - address width, DEPTH = 2**ADDR_W registers
//   ZERO_REG - when 1, register 0 reads as zero and ignores writes/claims
//
// Ports:
//   clk                    - single clock, rising edge
//   reset                  - synchronous, active-high; aborts a clear in progress
//   write/writeAddr/writeData - register write, also clears the pending bit
//   readAddr1/readAddr2    - combinational read ports
//   readData1/readData2    - read data
//   pending1/pending2      - pending bit of readAddr1/readAddr2
//   claim/claimAddr        - set the pending bit of claimAddr (wins over write)
//   clear_req              - request a sequential clear of all registers
//   clear_busy             - high exactly while the clear sequencer runs
//   dbgState               - sequencer state (0 = IDLE, 1 = CLEAR) for checkers
//
// Optional feature: define REGFILE_BYPASS_EN to forward a same-cycle write to
// the read ports; without it, reads show stored state only.
//
// Clear handshake: clear_req is sampled only in IDLE; once accepted,
// clear_busy rises at the next edge and stays high for exactly DEPTH cycles.
// While clear_busy is high, write, claim and clear_req are all ignored.

module regfile_scoreboard #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write,
  input  logic [ADDR_W-1:0] writeAddr,
  input  logic [WIDTH-1:0]  writeData,
  input  logic [ADDR_W-1:0] readAddr1,
  input  logic [ADDR_W-1:0] readAddr2,
  output logic [WIDTH-1:0]  readData1,
  output logic [WIDTH-1:0]  readData2,
  output logic              pending1,
  output logic              pending2,
  input  logic              claim,
  input  logic [ADDR_W-1:0] claimAddr,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              dbgState
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] clr_idx;
  logic [WIDTH-1:0]  regs [DEPTH];
  logic [DEPTH-1:0]  pending;

  logic writeEn;
  logic claimEn;

  // State register plus storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
      state   <= IDLE;
      clr_idx <= '0;
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          // Held at zero so a clear always starts at register 0.
          clr_idx <= '0;
          if (writeEn) begin
            regs[writeAddr]    <= writeData;
            pending[writeAddr] <= 1'b0;
          end
          // Placed after the write so a same-address claim wins.
          if (claimEn) pending[claimAddr] <= 1'b1;
        end
        CLEAR: begin
          regs[clr_idx]    <= '0;
          pending[clr_idx] <= 1'b0;
          // Hold at the last index rather than wrapping.
          if (clr_idx != LAST_IDX) clr_idx <= clr_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (clear_req) nextState = CLEAR;
      CLEAR:   if (clr_idx == LAST_IDX) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Outputs and qualified enables
  always_comb begin
    clear_busy = (state == CLEAR);
    dbgState   = state;
    writeEn    = write && (state == IDLE) &&
                 !((ZERO_REG != 0) && (writeAddr == '0));
    claimEn    = claim && (state == IDLE) &&
                 !((ZERO_REG != 0) && (claimAddr == '0));
  end

  // Read ports
  always_comb begin
    readData1 = regs[readAddr1];
    readData2 = regs[readAddr2];
    pending1  = pending[readAddr1];
    pending2  = pending[readAddr2];
`ifdef REGFILE_BYPASS_EN
    // writeEn already excludes register 0 when it is hardwired.
    if (writeEn && (writeAddr == readAddr1)) begin
      readData1 = writeData;
      pending1  = claimEn && (claimAddr == readAddr1);
    end
    if (writeEn && (writeAddr == readAddr2)) begin
      readData2 = writeData;
      pending2  = claimEn && (claimAddr == readAddr2);
    end
`endif
    if ((ZERO_REG != 0) && (readAddr1 == '0)) begin
      readData1 = '0;
      pending1  = 1'b0;
    end
    if ((ZERO_REG != 0) && (readAddr2 == '0)) begin
      readData2 = '0;
      pending2  = 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
module tb_regfile_scoreboard;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // main DUT (ZERO_REG = 0)
  logic         write, claim, clear_req;
  logic [1:0]   write_addr, claim_addr, read_addr1, read_addr2;
  logic [W-1:0] write_data, read_data1, read_data2;
  logic         pending1, pending2, clear_busy, dbg_state;

  regfile_scoreboard #(.WIDTH(W), .ADDR_W(2), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset),
    .write(write), .writeAddr(write_addr), .writeData(write_data),
    .readAddr1(read_addr1), .readAddr2(read_addr2),
    .readData1(read_data1), .readData2(read_data2),
    .pending1(pending1), .pending2(pending2),
    .claim(claim), .claimAddr(claim_addr),
    .clear_req(clear_req), .clear_busy(clear_busy), .dbgState(dbg_state)
  );

  // second DUT with register 0 hardwired to zero
  logic         z_write, z_claim;
  logic [1:0]   z_write_addr, z_claim_addr, z_read_addr1, z_read_addr2;
  logic [W-1:0] z_write_data, z_read_data1, z_read_data2;
  logic         z_pending1, z_pending2, z_clear_busy, z_dbg_state;

  regfile_scoreboard #(.WIDTH(W), .ADDR_W(2), .ZERO_REG(1)) zdut (
    .clk(clk), .reset(reset),
    .write(z_write), .writeAddr(z_write_addr), .writeData(z_write_data),
    .readAddr1(z_read_addr1), .readAddr2(z_read_addr2),
    .readData1(z_read_data1), .readData2(z_read_data2),
    .pending1(z_pending1), .pending2(z_pending2),
    .claim(z_claim), .claimAddr(z_claim_addr),
    .clear_req(1'b0), .clear_busy(z_clear_busy), .dbgState(z_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [2*W+1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic         wr;
    logic [1:0]   wa;
    logic [W-1:0] wd;
    logic         cl;
    logic [1:0]   ca;
    logic [1:0]   ra1;
    logic [1:0]   ra2;
    logic [W-1:0] e1;
    logic         ep1;
    logic [W-1:0] e2;
    logic         ep2;
  } vec_t;

  vec_t vecs [8];

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    write = 1'b0; claim = 1'b0; clear_req = 1'b0;
    write_addr = '0; claim_addr = '0; write_data = '0;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [W-1:0] d);
    @(negedge clk);
    write = 1'b1; write_addr = a; write_data = d;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic do_claim(input logic [1:0] a);
    @(negedge clk);
    claim = 1'b1; claim_addr = a;
    @(posedge clk); #1;
    claim = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 4; i += 2) begin
      read_addr1 = 2'(i); read_addr2 = 2'(i + 1);
      #1;
      check({tag, "_d1"}, 32'(read_data1), 32'h0);
      check({tag, "_d2"}, 32'(read_data2), 32'h0);
      check({tag, "_p"}, {30'h0, pending1, pending2}, 32'h0);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    int busy_cnt;
    logic [2*W+1:0] exp_v;

    // {wr, wa, wd, cl, ca, ra1, ra2, e1, ep1, e2, ep2}
    vecs[0] = '{1'b1, 2'd2, 16'hBEEF, 1'b0, 2'd0, 2'd2, 2'd0, 16'hBEEF, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 2'd0, 16'h0000, 1'b1, 2'd1, 2'd1, 2'd2, 16'h0000, 1'b1, 16'hBEEF, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 16'h1234, 1'b0, 2'd0, 2'd1, 2'd2, 16'h1234, 1'b0, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b1, 2'd3, 16'h00FF, 1'b1, 2'd3, 2'd3, 2'd1, 16'h00FF, 1'b1, 16'h1234, 1'b0};
    vecs[4] = '{1'b1, 2'd0, 16'h5A5A, 1'b1, 2'd2, 2'd0, 2'd2, 16'h5A5A, 1'b0, 16'hBEEF, 1'b1};
    vecs[5] = '{1'b1, 2'd2, 16'h0F0F, 1'b0, 2'd0, 2'd2, 2'd3, 16'h0F0F, 1'b0, 16'h00FF, 1'b1};
    vecs[6] = '{1'b1, 2'd3, 16'hFFFF, 1'b1, 2'd0, 2'd0, 2'd3, 16'h5A5A, 1'b1, 16'hFFFF, 1'b0};
    vecs[7] = '{1'b0, 2'd0, 16'h0000, 1'b0, 2'd0, 2'd1, 2'd0, 16'h1234, 1'b0, 16'h5A5A, 1'b1};

    idle_inputs();
    read_addr1 = '0; read_addr2 = '0;
    z_write = 1'b0; z_claim = 1'b0; z_write_addr = '0; z_claim_addr = '0;
    z_write_data = '0; z_read_addr1 = '0; z_read_addr2 = '0;

    // reset with random garbage on the inputs; reset must win
    reset = 1'b1;
    write = 1'b1; write_addr = 2'($urandom_range(0, 3)); write_data = 16'($urandom_range(1, 16'hFFFF));
    claim = 1'b1; claim_addr = 2'($urandom_range(0, 3)); clear_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;
    check("reset_busy", {31'h0, clear_busy}, 32'h0);
    check_all_zero("reset");

    // table-driven vectors through the scoreboard queue
    foreach (vecs[i]) begin
      @(negedge clk);
      write = vecs[i].wr; write_addr = vecs[i].wa; write_data = vecs[i].wd;
      claim = vecs[i].cl; claim_addr = vecs[i].ca;
      read_addr1 = vecs[i].ra1; read_addr2 = vecs[i].ra2;
      exp_q.push_back({vecs[i].e1, vecs[i].ep1, vecs[i].e2, vecs[i].ep2});
      @(posedge clk); #1;
      write = 1'b0; claim = 1'b0;
      #1;
      exp_v = exp_q.pop_front();
      check($sformatf("vec%0d_d1", i), 32'(read_data1), 32'(exp_v[2*W+1:W+2]));
      check($sformatf("vec%0d_p1", i), {31'h0, pending1}, {31'h0, exp_v[W+1]});
      check($sformatf("vec%0d_d2", i), 32'(read_data2), 32'(exp_v[W:1]));
      check($sformatf("vec%0d_p2", i), {31'h0, pending2}, {31'h0, exp_v[0]});
    end

    // same-cycle write visibility on the read port
    @(negedge clk);
    write = 1'b1; write_addr = 2'd1; write_data = 16'hA5A5;
    read_addr1 = 2'd1; read_addr2 = 2'd0;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("bypass_same_cycle", 32'(read_data1), 32'hA5A5);
`else
    check("bypass_same_cycle", 32'(read_data1), 32'h1234);
`endif
    check("bypass_pend", {31'h0, pending1}, 32'h0);
    @(posedge clk); #1;
    write = 1'b0;
    #1;
    check("bypass_after_edge", 32'(read_data1), 32'hA5A5);

    // sequential clear: all four registers hold nonzero data now
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;
    clear_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!clear_busy) break;
      read_addr1 = 2'd1; read_addr2 = 2'd3;
      #1;
      if (busy_cnt == 0) check("clear_dbg_state", {31'h0, dbg_state}, 32'h1);
      if (busy_cnt == 2) begin
        check("clear_mid_r1", 32'(read_data1), 32'h0);
        check("clear_mid_r3", 32'(read_data2), 32'hFFFF);
      end
      busy_cnt++;
      // all of these must be ignored while busy
      write = 1'b1; write_addr = 2'(busy_cnt % 4); write_data = 16'h7777;
      claim = 1'b1; claim_addr = 2'd3; clear_req = 1'b1;
    end
    idle_inputs();
    check("clear_busy_cycles", 32'(busy_cnt), 32'd4);
    @(posedge clk); #1;
    check("clear_no_restart", {31'h0, clear_busy}, 32'h0);
    check_all_zero("after_clear");

    // reset aborts a clear in progress
    do_write(2'd3, 16'h1111);
    do_write(2'd1, 16'h2222);
    do_claim(2'd2);
    @(negedge clk);
    clear_req = 1'b1;
    @(posedge clk); #1;          // enter CLEAR
    clear_req = 1'b0;
    @(posedge clk); #1;          // first CLEAR cycle done, now in the second
    check("abort_busy_before", {31'h0, clear_busy}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy_after", {31'h0, clear_busy}, 32'h0);
    check("abort_state", {31'h0, dbg_state}, 32'h0);
    check_all_zero("after_abort");

    // hardwired register 0
    @(negedge clk);
    z_write = 1'b1; z_write_addr = 2'd0; z_write_data = 16'hFFFF;
    z_claim = 1'b1; z_claim_addr = 2'd0; z_read_addr1 = 2'd0; z_read_addr2 = 2'd2;
    #1;
    check("zero_bypass_d", 32'(z_read_data1), 32'h0);
    @(posedge clk); #1;
    z_write_addr = 2'd2; z_write_data = 16'h4321; z_claim = 1'b0;
    @(posedge clk); #1;
    z_write = 1'b0;
    #1;
    check("zero_r0_d", 32'(z_read_data1), 32'h0);
    check("zero_r0_p", {31'h0, z_pending1}, 32'h0);
    check("zero_r2_d", 32'(z_read_data2), 32'h4321);
    check("zero_busy", {31'h0, z_clear_busy}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
